// File: rtl/gpzda_field_parser.sv
// ZDA sentence body parser: takes bytes after the "$GPZDA" header match and
// produces UTC time/date fields with a checksum-verified valid/error pulse.
module gpzda_field_parser #(
  parameter int unsigned B          = 8,
  parameter logic [7:0]  HEADER_XOR = 8'h48
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          load,
  input  logic [B-1:0]  data,
  output logic [4:0]    hour,
  output logic [5:0]    minute,
  output logic [5:0]    second,
  output logic [4:0]    day,
  output logic [3:0]    month,
  output logic [11:0]   year,
  output logic          valid,
  output logic          error,
  output logic [2:0]    err_code
);

  typedef enum logic [3:0] {
    IDLE, C0, TIME, FRAC, DAY, MON, YEAR, SKIP, CK_HI, CK_LO
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  cks_q, cks_d;
  logic [3:0]  ckhi_q, ckhi_d;
  logic [6:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [4:0]  dd_q, dd_d;
  logic [3:0]  mo_q, mo_d;
  logic [11:0] yr_q, yr_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  minute_q, minute_d, second_q, second_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic        valid_q, valid_d, error_q, error_d;
  logic [2:0]  err_code_q, err_code_d;

  logic        is_digit, is_hex, is_comma;
  logic [3:0]  hex_val;
  logic [11:0] acc_next;
  logic        fail;
  logic [2:0]  fail_code;

  assign is_digit = (data >= 8'h30) && (data <= 8'h39);
  assign is_hex   = is_digit || ((data >= 8'h41) && (data <= 8'h46));
  assign is_comma = (data == 8'h2C);
  assign hex_val  = is_digit ? data[3:0] : data[3:0] + 4'd9;
  assign acc_next = acc_q * 12'd10 + {8'd0, data[3:0]};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cks_d      = cks_q;
    ckhi_d     = ckhi_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    dd_d       = dd_q;
    mo_d       = mo_q;
    yr_d       = yr_q;
    hour_d     = hour_q;
    minute_d   = minute_q;
    second_d   = second_q;
    day_d      = day_q;
    month_d    = month_q;
    year_d     = year_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = 3'd1;

    if (start) begin
      state_d = C0;
      cks_d   = HEADER_XOR;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (load && state_q != IDLE) begin
      if (data == 8'h24) begin
        fail      = 1'b1;
        fail_code = 3'd4;
      end else begin
        if (state_q != CK_HI && state_q != CK_LO && data != 8'h2A)
          cks_d = cks_q ^ data;
        case (state_q)
          C0: begin
            if (is_comma) begin
              state_d = TIME;
              acc_d   = '0;
              cnt_d   = '0;
            end else fail = 1'b1;
          end
          // TIME splits into three 2-digit pairs; each pair is latched on its second digit
          TIME: begin
            if (is_digit) begin
              if (cnt_q == 3'd6) fail = 1'b1;
              else begin
                cnt_d = cnt_q + 3'd1;
                acc_d = acc_next;
                if (cnt_q[0]) begin
                  acc_d = '0;
                  case (cnt_q)
                    3'd1:    hh_d = acc_next[6:0];
                    3'd3:    mm_d = acc_next[6:0];
                    default: ss_d = acc_next[6:0];
                  endcase
                end
              end
            end else if (is_comma || data == 8'h2E) begin
              if (cnt_q != 3'd6) fail = 1'b1;
              else if (hh_q > 7'd23 || mm_q > 7'd59 || ss_q > 7'd60) begin
                fail      = 1'b1;
                fail_code = 3'd2;
              end else begin
                state_d = is_comma ? DAY : FRAC;
                acc_d   = '0;
                cnt_d   = '0;
              end
            end else fail = 1'b1;
          end
          FRAC: begin
            if (is_comma) state_d = DAY;
            else if (!is_digit) fail = 1'b1;
          end
          DAY, MON, YEAR: begin
            if (is_digit) begin
              if (cnt_q == ((state_q == YEAR) ? 3'd4 : 3'd2)) fail = 1'b1;
              else begin
                cnt_d = cnt_q + 3'd1;
                acc_d = acc_next;
              end
            end else if (is_comma) begin
              acc_d = '0;
              cnt_d = '0;
              if (cnt_q != ((state_q == YEAR) ? 3'd4 : 3'd2)) fail = 1'b1;
              else if (state_q == DAY) begin
                if (acc_q == 12'd0 || acc_q > 12'd31) begin
                  fail      = 1'b1;
                  fail_code = 3'd2;
                end else begin
                  dd_d    = acc_q[4:0];
                  state_d = MON;
                end
              end else if (state_q == MON) begin
                if (acc_q == 12'd0 || acc_q > 12'd12) begin
                  fail      = 1'b1;
                  fail_code = 3'd2;
                end else begin
                  mo_d    = acc_q[3:0];
                  state_d = YEAR;
                end
              end else begin
                yr_d    = acc_q;
                state_d = SKIP;
              end
            end else fail = 1'b1;
          end
          SKIP: begin
            if (data == 8'h2A) state_d = CK_HI;
          end
          CK_HI: begin
            if (is_hex) begin
              ckhi_d  = hex_val;
              state_d = CK_LO;
            end else fail = 1'b1;
          end
          CK_LO: begin
            if (!is_hex) fail = 1'b1;
            else if ({ckhi_q, hex_val} != cks_q) begin
              fail      = 1'b1;
              fail_code = 3'd3;
            end else begin
              valid_d  = 1'b1;
              state_d  = IDLE;
              hour_d   = hh_q[4:0];
              minute_d = mm_q[5:0];
              second_d = ss_q[5:0];
              day_d    = dd_q;
              month_d  = mo_q;
              year_d   = yr_q;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      if (fail) begin
        error_d    = 1'b1;
        err_code_d = fail_code;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      cks_q      <= '0;
      ckhi_q     <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      dd_q       <= '0;
      mo_q       <= '0;
      yr_q       <= '0;
      hour_q     <= '0;
      minute_q   <= '0;
      second_q   <= '0;
      day_q      <= '0;
      month_q    <= '0;
      year_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      cks_q      <= cks_d;
      ckhi_q     <= ckhi_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      dd_q       <= dd_d;
      mo_q       <= mo_d;
      yr_q       <= yr_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign hour     = hour_q;
  assign minute   = minute_q;
  assign second   = second_q;
  assign day      = day_q;
  assign month    = month_q;
  assign year     = year_q;
  assign valid    = valid_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_gpzda_field_parser.sv
// Scoreboard bench for gpzda_field_parser: stimulus pushes expected pulses,
// a negedge monitor pops and checks each valid/error pulse.
module tb_gpzda_field_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        load  = 1'b0;
  logic [7:0]  data  = '0;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;
  logic        valid;
  logic        error;
  logic [2:0]  err_code;

  gpzda_field_parser #(.B(8), .HEADER_XOR(8'h48)) dut (
    .clock(clock), .reset(reset), .start(start), .load(load), .data(data),
    .hour(hour), .minute(minute), .second(second), .day(day), .month(month),
    .year(year), .valid(valid), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_err;
    int code;
    int hh, mi, ss, dd, mo, yy;
    int byte_no;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int bytes_sent = 0;
  int loaded_bytes = 0;
  int cyc = 0;
  int last_load_cyc = -1;
  int cur_hh = 0, cur_mi = 0, cur_ss = 0, cur_dd = 0, cur_mo = 0, cur_yy = 0;
  int cur_code = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (load && !reset) begin
      loaded_bytes++;
      last_load_cyc = cyc;
    end
  end

  always @(negedge clock) begin
    if (valid || error) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid", int'(valid), e.is_err ? 0 : 1);
        chk("error", int'(error), e.is_err ? 1 : 0);
        chk("err_code", int'(err_code), e.code);
        chk("hour", int'(hour), e.hh);
        chk("minute", int'(minute), e.mi);
        chk("second", int'(second), e.ss);
        chk("day", int'(day), e.dd);
        chk("month", int'(month), e.mo);
        chk("year", int'(year), e.yy);
        chk("deciding_byte", loaded_bytes, e.byte_no);
        chk("latency", last_load_cyc, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    tick();
    load = 1'b1;
    data = b;
    tick();
    load = 1'b0;
    bytes_sent++;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_valid(input int hh, mi, ss, dd, mo, yy, input int pos);
    exp_t e;
    cur_hh = hh; cur_mi = mi; cur_ss = ss; cur_dd = dd; cur_mo = mo; cur_yy = yy;
    e.is_err = 1'b0; e.code = cur_code;
    e.hh = hh; e.mi = mi; e.ss = ss; e.dd = dd; e.mo = mo; e.yy = yy;
    e.byte_no = bytes_sent + pos;
    q.push_back(e);
  endtask

  task automatic expect_error(input int code, input int pos);
    exp_t e;
    cur_code = code;
    e.is_err = 1'b1; e.code = code;
    e.hh = cur_hh; e.mi = cur_mi; e.ss = cur_ss; e.dd = cur_dd; e.mo = cur_mo; e.yy = cur_yy;
    e.byte_no = bytes_sent + pos;
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hour"}, int'(hour), 0);
    chk({tag, "_minute"}, int'(minute), 0);
    chk({tag, "_second"}, int'(second), 0);
    chk({tag, "_day"}, int'(day), 0);
    chk({tag, "_month"}, int'(month), 0);
    chk({tag, "_year"}, int'(year), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_error"}, int'(error), 0);
  endtask

  string s1   = ",201530.00,04,07,2002,00,00*60";
  string s1b  = ",201530.00,04,07,2002,00,00*61";
  string s3   = ",201530.00,04,13,2002,00,00*60";
  string s4   = ",20153.00,04,07,2002,00,00*60";
  string sl   = ",235960,31,12,4095,00,00*4A";
  string slc  = ",235960,31,12,4095,00,00*4a";

  initial begin
    wait_cycles(3);
    reset = 1'b0;
    tick();
    @(negedge clock);
    check_all_zero("reset");

    // bad checksum right after reset: fields stay 0
    pulse_start();
    expect_error(3, s1b.len());
    send_str(s1b);
    wait_cycles(4);

    // good sentence
    pulse_start();
    expect_valid(20, 15, 30, 4, 7, 2002, s1.len());
    send_str(s1);
    wait_cycles(4);
    send_str("\r\n");

    // month 13: range error at the terminating comma, rest ignored
    pulse_start();
    expect_error(2, 17);
    send_str(s3);
    wait_cycles(4);

    // five time digits: format error at '.', then leap-second sentence
    pulse_start();
    expect_error(1, 7);
    send_str(s4);
    wait_cycles(4);
    pulse_start();
    expect_valid(23, 59, 60, 31, 12, 4095, sl.len());
    send_str(sl);
    wait_cycles(4);

    // lowercase checksum digit is a format error
    pulse_start();
    expect_error(1, slc.len());
    send_str(slc);
    wait_cycles(4);

    // '$' mid-time, then restart from DAY, then a good sentence
    pulse_start();
    expect_error(4, 6);
    send_str(",2015$");
    wait_cycles(4);
    pulse_start();
    send_str(",201530,0");
    pulse_start();
    expect_valid(20, 15, 30, 4, 7, 2002, s1.len());
    send_str(s1);
    wait_cycles(4);

    // reset during the year digits: no pulse, everything back to 0
    pulse_start();
    send_str(",201530.00,04,07,20");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cur_hh = 0; cur_mi = 0; cur_ss = 0; cur_dd = 0; cur_mo = 0; cur_yy = 0; cur_code = 0;
    send_str("02,00,00*60");
    wait_cycles(4);
    @(negedge clock);
    check_all_zero("after_reset");

    wait_cycles(4);
    chk("pending_expectations", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
